// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO onto a serial line, 1 start / 8 data (LSB first) / 1 stop.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [7:0]       fifo_rd_data,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] bytes_sent
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state, state_n;
    logic [BW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          tick, tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
    logic          par;
`endif

    assign tick       = cnt == LAST;
    assign busy       = state != IDLE;
    assign fifo_rd_en = state == IDLE && tx_enable && !fifo_empty;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = fifo_rd_en ? START : IDLE;
            START:  state_n = tick ? DATA : START;
`ifdef FIFO_UART_TX_PARITY_EN
            DATA:   state_n = tick && idx == 3'd7 ? PARITY : DATA;
            PARITY: state_n = tick ? STOP : PARITY;
`else
            DATA:   state_n = tick && idx == 3'd7 ? STOP : DATA;
`endif
            STOP:   state_n = tick ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // tx is registered from the next state, so it changes on the same edge as the state
    always_comb begin
        tx_d = 1'b1;
        case (state_n)
            START:  tx_d = 1'b0;
            DATA:   tx_d = state == DATA && tick ? shift[1] : shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: tx_d = par;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt        <= '0;
            idx        <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            bytes_sent <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            tx  <= tx_d;
            cnt <= state == IDLE || tick ? '0 : cnt + 1'b1;
            if (fifo_rd_en) begin
                shift <= fifo_rd_data;
                idx   <= '0;
            end else if (state == DATA && tick) begin
                shift <= shift >> 1;
                idx   <= idx + 1'b1;
            end
`ifdef FIFO_UART_TX_PARITY_EN
            if (fifo_rd_en) par <= ^fifo_rd_data;
`endif
            if (state == STOP && tick) bytes_sent <= bytes_sent + 1'b1;
        end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed bench for fifo_uart_tx with a small FIFO model and per-frame waveform checks.
module tb_fifo_uart_tx;
    localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic       clk = 1'b0;
    logic       reset, tx_enable, fifo_empty, fifo_rd_en, tx, busy;
    logic [7:0] fifo_rd_data;
    logic [3:0] bytes_sent;

    logic [7:0] mem [0:31];
    int wp = 0, rp = 0, rd_cnt = 0, cyc = 0;
    int n_tests = 0, n_fail = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .tx(tx), .busy(busy),
        .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    assign fifo_empty   = wp == rp;
    assign fifo_rd_data = mem[rp[4:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !reset) begin
            rp     <= rp + 1;
            rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp[4:0]] = b;
        wp = wp + 1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        int s = (k - 1) / CPB;
        if (s == 0) return 1'b0;
        if (s <= 8) return b[s-1];
`ifdef FIFO_UART_TX_PARITY_EN
        if (s == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // waits (bounded) for the fetch, checks every frame cycle, then the idle cycle after it
    task automatic frame(input logic [7:0] b, input int drop_at, output int fc);
        int n = 0, errs = 0;
        #1;
        while (!fifo_rd_en && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("fetch_%02h", b), fifo_rd_en, 1);
        fc = cyc;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == drop_at) tx_enable = 1'b0;
            if (tx !== exp_bit(b, k) || busy !== 1'b1 || fifo_rd_en !== 1'b0) errs++;
        end
        check($sformatf("frame_%02h", b), errs, 0);
        @(negedge clk);
        check($sformatf("gap_busy_%02h", b), busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, f1, f2, errs;
        logic [7:0] wrap_bytes [0:15];
        reset = 1'b1;
        tx_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_sent", bytes_sent, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        reset = 1'b0;

        push(8'hA5);
        tx_enable = 1'b1;
        frame(8'hA5, 0, f0);
        check("t1_sent", bytes_sent, 1);
        check("t1_rd_cnt", rd_cnt, 1);

        push(8'h01); push(8'h80); push(8'hFF);
        frame(8'h01, 0, f0);
        frame(8'h80, 0, f1);
        frame(8'hFF, 0, f2);
        check("t2_spacing_a", f1 - f0, FRAME + 1);
        check("t2_spacing_b", f2 - f1, FRAME + 1);
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("t2_idle", errs, 0);
        check("t2_sent", bytes_sent, 4);
        check("t2_rd_cnt", rd_cnt, 4);

        tx_enable = 1'b0;
        push(8'h3C);
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("t3_held_off", errs, 0);
        tx_enable = 1'b1;
        #1;
        check("t3_rd_en_same_cycle", fifo_rd_en, 1);
        frame(8'h3C, 0, f0);
        check("t3_sent", bytes_sent, 5);

        push(8'h11); push(8'h22);
        frame(8'h11, 10, f0);
        check("t4_no_fetch", fifo_rd_en, 0);
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) errs++;
        end
        check("t4_idle", errs, 0);
        check("t4_second_held", fifo_empty, 0);
        check("t4_rd_cnt", rd_cnt, 6);
        check("t4_sent", bytes_sent, 6);

        tx_enable = 1'b1;
        #1;
        check("t5_fetch", fifo_rd_en, 1);
        repeat (20) @(negedge clk);
        check("t5_pre_tx", tx, 0);
        reset = 1'b1;
        #1;
        check("t5_async_tx", tx, 1);
        check("t5_async_busy", busy, 0);
        check("t5_async_sent", bytes_sent, 0);
        @(negedge clk);
        reset = 1'b0;
        check("t5_no_reread", fifo_empty, 1);
        check("t5_rd_cnt", rd_cnt, 7);
        push(8'h5A);
        frame(8'h5A, 0, f0);
        check("t5_sent", bytes_sent, 1);
        check("t5_rd_cnt_after", rd_cnt, 8);

        for (int i = 0; i < 16; i++) begin
            wrap_bytes[i] = i == 0 ? 8'h07 : 8'(i * 29 + 3);
            push(wrap_bytes[i]);
        end
        for (int i = 0; i < 16; i++) begin
            frame(wrap_bytes[i], 0, f0);
            check($sformatf("t6_sent_%0d", i), bytes_sent, (i + 2) % 16);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
